// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer: feeds one external single-digit
// BCD adder per clock, least-significant digit first, and assembles the result.
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                Cin,
   output logic [3:0]          da_a,
   output logic [3:0]          da_b,
   output logic                da_cin,
   input  logic [3:0]          da_sum,
   input  logic                da_cout,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] sum,
   output logic                Cout,
   output logic                err
);

   localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e              state_q;
   logic [IW-1:0]       idx_q;
   logic                carry_q;
   logic [4*DIGITS-1:0] a_q;
   logic [4*DIGITS-1:0] b_q;
   logic [4*DIGITS-1:0] sum_q;
   logic                busy_q;
   logic                done_q;
   logic                cout_q;
   logic                err_q;
   logic                bad_digit;

   // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // The shared digit adder sees the current digit pair only while running.
   always_comb begin
      da_a   = 4'd0;
      da_b   = 4'd0;
      da_cin = 1'b0;
      if (state_q == RUN) begin
         da_a   = a_q[4*idx_q +: 4];
         da_b   = b_q[4*idx_q +: 4];
         da_cin = carry_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= Cin;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  err_q   <= bad_digit;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[4*idx_q +: 4] <= da_sum;
               carry_q             <= da_cout;
               idx_q               <= idx_q + IW'(1);
               if (idx_q == LAST) begin
                  cout_q  <= da_cout;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign Cout = cout_q;
   assign err  = err_q;

endmodule
